// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared constants and types for the memory arbiter
// Requester indices, requester count, sign/size encoding and counter width.
package mem_arbiter_pkg;

  localparam int NumReq     = 3;
  localparam int ReqFetch   = 0;
  localparam int ReqLsu     = 1;
  localparam int ReqDebug   = 2;

  // sign_size = {unsigned, size[1:0]}
  localparam int SignSizeW  = 3;
  localparam int StarveCntW = 4;

  typedef enum logic [1:0] {
    SizeByte = 2'd0,
    SizeHalf = 2'd1,
    SizeWord = 2'd2
  } size_e;

endpackage

// File: rtl/mem_arbiter_prio.sv
// rtl/mem_arbiter_prio.sv - combinational fixed-priority picker with fetch boost
// Ports:
//   valid - per-requester request (fetch, lsu, debug)
//   boost - promote fetch above load/store
//   grant - one-hot winner, all-zero when nothing is valid
module mem_arbiter_prio
  import mem_arbiter_pkg::*;
(
  input  logic [NumReq-1:0] valid,
  input  logic              boost,
  output logic [NumReq-1:0] grant
);

  // Debug always wins; boost only swaps the order of fetch and load/store.
  always_comb begin
    grant = '0;
    if (valid[ReqDebug]) begin
      grant[ReqDebug] = 1'b1;
    end else if (boost && valid[ReqFetch]) begin
      grant[ReqFetch] = 1'b1;
    end else if (valid[ReqLsu]) begin
      grant[ReqLsu] = 1'b1;
    end else if (valid[ReqFetch]) begin
      grant[ReqFetch] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-requester memory arbiter with fetch starvation boost
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   req_valid/write/addr/sign_size/wdata, req_ready - requester side (0 fetch, 1 lsu, 2 debug)
//   rsp_valid/data/malign/fault     - response, one cycle after acceptance
//   mem_address/sign_size/rd/wr/data_in - request towards the memory interface
//   mem_complete/data_out/malign/fault  - status and read data from the memory interface
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AddrWidth   = 32,
  parameter int DataWidth   = 32,
  parameter int StarveLimit = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NumReq-1:0]              req_valid,
  input  logic [NumReq-1:0]              req_write,
  input  logic [NumReq*AddrWidth-1:0]    req_addr,
  input  logic [NumReq*SignSizeW-1:0]    req_sign_size,
  input  logic [NumReq*DataWidth-1:0]    req_wdata,
  output logic [NumReq-1:0]              req_ready,
  output logic [NumReq-1:0]              rsp_valid,
  output logic [DataWidth-1:0]           rsp_data,
  output logic                           rsp_malign,
  output logic                           rsp_fault,
  output logic [AddrWidth-1:0]           mem_address,
  output logic [SignSizeW-1:0]           mem_sign_size,
  output logic                           mem_rd,
  output logic                           mem_wr,
  output logic [DataWidth-1:0]           mem_data_in,
  input  logic                           mem_complete,
  input  logic [DataWidth-1:0]           mem_data_out,
  input  logic                           mem_malign,
  input  logic                           mem_fault
);

  localparam logic [StarveCntW-1:0] StarveMax = StarveCntW'(StarveLimit);

  logic [NumReq-1:0]     grant;
  logic                  boost;
  logic                  sel_write;
  logic                  rsp_unsigned;

  logic [NumReq-1:0]     rsp_owner_q, rsp_owner_d;
  logic [SignSizeW-1:0]  rsp_sign_size_q, rsp_sign_size_d;
  logic [StarveCntW-1:0] starve_cnt_q, starve_cnt_d;

  assign boost = (starve_cnt_q == StarveMax);

  mem_arbiter_prio u_prio (
    .valid (req_valid),
    .boost (boost),
    .grant (grant)
  );

  // Route the winner onto the memory request; everything idles at zero
  // when nobody is granted.
  always_comb begin
    mem_address   = '0;
    mem_sign_size = '0;
    mem_data_in   = '0;
    sel_write     = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant[i]) begin
        mem_address   = req_addr[i*AddrWidth +: AddrWidth];
        mem_sign_size = req_sign_size[i*SignSizeW +: SignSizeW];
        mem_data_in   = req_wdata[i*DataWidth +: DataWidth];
        sel_write     = req_write[i];
      end
    end
    mem_rd    = (|grant) && !sel_write && !rst;
    mem_wr    = (|grant) &&  sel_write && !rst;
    // A stalled memory holds the request; arbitration re-runs next cycle.
    req_ready = rst ? '0 : (grant & {NumReq{mem_complete}});
  end

  always_comb begin
    rsp_owner_d     = req_ready;
    rsp_sign_size_d = mem_sign_size;
    starve_cnt_d    = starve_cnt_q;
    if (!req_valid[ReqFetch] || req_ready[ReqFetch]) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != StarveMax) begin
      starve_cnt_d = starve_cnt_q + StarveCntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_owner_q     <= '0;
      rsp_sign_size_q <= '0;
      starve_cnt_q    <= '0;
    end else begin
      rsp_owner_q     <= rsp_owner_d;
      rsp_sign_size_q <= rsp_sign_size_d;
      starve_cnt_q    <= starve_cnt_d;
    end
  end

  // Masking with rst drops a response whose acceptance happened in the
  // cycle just before reset asserted.
  assign rsp_unsigned = rsp_sign_size_q[2];

  always_comb begin
    rsp_valid  = rst ? '0 : rsp_owner_q;
    rsp_malign = mem_malign;
    rsp_fault  = mem_fault;
    rsp_data   = mem_data_out;
    case (size_e'(rsp_sign_size_q[1:0]))
      SizeByte: rsp_data = {{(DataWidth-8){!rsp_unsigned && mem_data_out[7]}},
                            mem_data_out[7:0]};
      SizeHalf: rsp_data = {{(DataWidth-16){!rsp_unsigned && mem_data_out[15]}},
                            mem_data_out[15:0]};
      SizeWord: rsp_data = mem_data_out;
      default:  rsp_data = mem_data_out;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with directed vectors
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_write;
  logic [95:0] req_addr;
  logic [8:0]  req_sign_size;
  logic [95:0] req_wdata;
  logic [2:0]  req_ready;
  logic [2:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_malign;
  logic        rsp_fault;
  logic [31:0] mem_address;
  logic [2:0]  mem_sign_size;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_data_in;
  logic        mem_complete;
  logic [31:0] mem_data_out = 32'h0;
  logic        mem_malign = 1'b0;
  logic        mem_fault = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          stamp;
    logic [2:0]  owner;
    logic [31:0] data;
    bit          chk_data;
    bit          malign;
    bit          fault;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_sign_size (req_sign_size),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_malign    (rsp_malign),
    .rsp_fault     (rsp_fault),
    .mem_address   (mem_address),
    .mem_sign_size (mem_sign_size),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .mem_data_in   (mem_data_in),
    .mem_complete  (mem_complete),
    .mem_data_out  (mem_data_out),
    .mem_malign    (mem_malign),
    .mem_fault     (mem_fault)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: raw right-aligned read data is a fixed function of the address.
  function automatic logic [31:0] model_data(input logic [31:0] a);
    if (a == 32'h0000_1002) return 32'h0000_8000;
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) begin
    if (!rst && mem_complete && (mem_rd || mem_wr)) begin
      mem_data_out <= mem_rd ? model_data(mem_address) : 32'h0;
      mem_malign   <= (mem_sign_size[1:0] == 2'd1 && mem_address[0]) ||
                      (mem_sign_size[1:0] == 2'd2 && mem_address[1:0] != 2'd0);
      mem_fault    <= (mem_address[31:28] == 4'hF);
    end else begin
      mem_data_out <= 32'h0;
      mem_malign   <= 1'b0;
      mem_fault    <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a response is due exactly one cycle after its acceptance was pushed.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].stamp < cyc - 1) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_missing: got no response, expected owner %b data %h",
               sb[0].owner, sb[0].data);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].stamp == cyc - 1) begin
      mon_e = sb.pop_front();
      check("rsp_valid", 32'(rsp_valid), 32'(mon_e.owner));
      if (mon_e.chk_data) check("rsp_data", rsp_data, mon_e.data);
      check("rsp_malign", 32'(rsp_malign), 32'(mon_e.malign));
      check("rsp_fault", 32'(rsp_fault), 32'(mon_e.fault));
    end else if (rsp_valid !== 3'b000) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_unexpected: got rsp_valid %b expected 000", rsp_valid);
    end
  end

  task automatic clear_req();
    req_valid     = '0;
    req_write     = '0;
    req_addr      = '0;
    req_sign_size = '0;
    req_wdata     = '0;
  endtask

  task automatic set_req(input int idx, input logic wr, input logic [31:0] addr,
                         input logic [2:0] ss, input logic [31:0] wd);
    req_valid[idx]             = 1'b1;
    req_write[idx]             = wr;
    req_addr[idx*32 +: 32]     = addr;
    req_sign_size[idx*3 +: 3]  = ss;
    req_wdata[idx*32 +: 32]    = wd;
  endtask

  task automatic drop_req(input int idx);
    req_valid[idx] = 1'b0;
  endtask

  // One cycle: check req_ready, push the expected response, advance to just after the edge.
  task automatic step(input string name, input logic [2:0] exp_ready, input bit push,
                      input logic [31:0] exp_data, input bit chk_data,
                      input bit exp_malign, input bit exp_fault);
    @(negedge clk);
    check({name, "_ready"}, 32'(req_ready), 32'(exp_ready));
    if (push) sb.push_back('{cyc, exp_ready, exp_data, chk_data, exp_malign, exp_fault});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clear_req();
    for (int i = 0; i < n; i++) step("idle", 3'b000, 0, 32'h0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    mem_complete = 1'b1;
    clear_req();
    @(posedge clk);
    #1;

    // Reset gating with every requester asking
    set_req(0, 0, 32'h0000_0300, 3'b010, 32'h0);
    set_req(1, 0, 32'h0000_0200, 3'b010, 32'h0);
    set_req(2, 0, 32'h0000_0100, 3'b010, 32'h0);
    @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'h0);
    check("reset_mem_rd", 32'(mem_rd), 32'h0);
    check("reset_mem_wr", 32'(mem_wr), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_req();
    @(negedge clk);
    check("post_reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("post_reset_starve", 32'(dut.starve_cnt_q), 32'h0);
    check("idle_mem_rd", 32'(mem_rd), 32'h0);
    check("idle_mem_address", mem_address, 32'h0);
    @(posedge clk);
    #1;

    // Debug wins over everything at starve count 0
    set_req(0, 0, 32'h0000_0300, 3'b010, 32'h0);
    set_req(1, 0, 32'h0000_0200, 3'b010, 32'h0);
    set_req(2, 0, 32'h0000_0100, 3'b010, 32'h0);
    step("all3", 3'b100, 1, 32'hA5A5_0100, 1, 0, 0);
    idle(1);

    // Fetch starved by lsu for four cycles, then boosted ahead of lsu
    set_req(0, 0, 32'h0000_0040, 3'b010, 32'h0);
    set_req(1, 0, 32'h0000_0080, 3'b010, 32'h0);
    for (int i = 0; i < 4; i++) step("starve_lsu", 3'b010, 1, 32'hA5A5_0080, 1, 0, 0);
    step("starve_boost", 3'b001, 1, 32'hA5A5_0040, 1, 0, 0);
    clear_req();
    @(negedge clk);
    check("starve_cleared", 32'(dut.starve_cnt_q), 32'h0);
    @(posedge clk);
    #1;
    idle(1);

    // Load extension of right-aligned data, back to back
    set_req(1, 0, 32'h0000_1002, 3'b001, 32'h0);
    step("ld_half_s", 3'b010, 1, 32'hFFFF_8000, 1, 0, 0);
    set_req(1, 0, 32'h0000_00F3, 3'b100, 32'h0);
    step("ld_byte_u", 3'b010, 1, 32'h0000_00F3, 1, 0, 0);
    set_req(1, 0, 32'h0000_0081, 3'b000, 32'h0);
    step("ld_byte_s", 3'b010, 1, 32'hFFFF_FF81, 1, 0, 0);
    set_req(1, 0, 32'h0000_1006, 3'b101, 32'h0);
    step("ld_half_u", 3'b010, 1, 32'h0000_1006, 1, 0, 0);
    idle(1);

    // Memory stall: request held three cycles, one acceptance, one response
    mem_complete = 1'b0;
    set_req(1, 0, 32'h0000_0300, 3'b010, 32'h0);
    #1;
    check("stall_mem_rd", 32'(mem_rd), 32'h1);
    check("stall_mem_address", mem_address, 32'h0000_0300);
    for (int i = 0; i < 3; i++) step("stall_hold", 3'b000, 0, 32'h0, 0, 0, 0);
    mem_complete = 1'b1;
    step("stall_accept", 3'b010, 1, 32'hA5A5_0300, 1, 0, 0);
    idle(2);

    // Starvation saturates on inhibited cycles; debug preempts a boosted fetch
    mem_complete = 1'b0;
    set_req(0, 0, 32'h0000_0010, 3'b010, 32'h0);
    for (int i = 0; i < 5; i++) step("sat_hold", 3'b000, 0, 32'h0, 0, 0, 0);
    check("starve_saturated", 32'(dut.starve_cnt_q), 32'h4);
    mem_complete = 1'b1;
    set_req(2, 0, 32'h0000_0020, 3'b010, 32'h0);
    step("preempt_debug", 3'b100, 1, 32'hA5A5_0020, 1, 0, 0);
    check("starve_held", 32'(dut.starve_cnt_q), 32'h4);
    drop_req(2);
    set_req(1, 0, 32'h0000_0030, 3'b010, 32'h0);
    step("boost_fetch", 3'b001, 1, 32'hA5A5_0010, 1, 0, 0);
    check("starve_after_fetch", 32'(dut.starve_cnt_q), 32'h0);
    idle(1);

    // Back-to-back fetches
    set_req(0, 0, 32'h0000_0000, 3'b010, 32'h0);
    step("fetch0", 3'b001, 1, 32'hA5A5_0000, 1, 0, 0);
    set_req(0, 0, 32'h0000_0004, 3'b010, 32'h0);
    step("fetch4", 3'b001, 1, 32'hA5A5_0004, 1, 0, 0);
    idle(1);

    // Write path, misaligned and faulting accesses
    set_req(1, 1, 32'h0000_0500, 3'b010, 32'hDEAD_BEEF);
    #1;
    check("wr_mem_wr", 32'(mem_wr), 32'h1);
    check("wr_mem_rd", 32'(mem_rd), 32'h0);
    check("wr_mem_data_in", mem_data_in, 32'hDEAD_BEEF);
    step("write", 3'b010, 1, 32'h0, 0, 0, 0);
    set_req(1, 0, 32'h0000_0002, 3'b010, 32'h0);
    step("malign", 3'b010, 1, 32'hA5A5_0002, 1, 1, 0);
    set_req(1, 0, 32'hF000_0000, 3'b010, 32'h0);
    step("fault", 3'b010, 1, 32'h55A5_0000, 1, 0, 1);
    idle(1);

    // Acceptance followed immediately by reset produces no response
    set_req(1, 0, 32'h0000_0700, 3'b010, 32'h0);
    step("pre_reset_accept", 3'b010, 0, 32'h0, 0, 0, 0);
    rst = 1'b1;
    set_req(0, 0, 32'h0000_0040, 3'b010, 32'h0);
    set_req(2, 0, 32'h0000_0050, 3'b010, 32'h0);
    #1;
    check("rst_mem_rd", 32'(mem_rd), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    check("rst_drop_n1", 32'(rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_req();
    @(negedge clk);
    check("rst_drop_n2", 32'(rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    idle(2);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
